button_debounce_array: RTL and testbench

Parametrised multi-channel pushbutton conditioner: N independent channels, each with a two-flop input synchroniser, a programmable stable-time filter, and single-cycle press/release strobes. Optional auto-repeat re-issues press strobes while a button is held. It sits between the raw board switches and the game logic, replacing the fixed two-sample single-button de-bouncer.

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/debounce_chan.sv | 128 ++++++++++++
 rtl/button_debounce_array.sv | 48 ++++
 tb/tb_button_debounce_array.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and elaboration-time helpers for the pushbutton conditioner.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    P_VERIFY = 2'd1,
    HELD     = 2'd2,
    R_VERIFY = 2'd3
  } deb_state_e;

  // True when a terminal count of (value-1) is reachable in a width-bit counter
  // without wrapping, and the value itself is a legal (non-zero) interval.
  function automatic bit count_fits(longint unsigned value, int unsigned width);
    if (value == 0) begin
      return 1'b0;
    end
    if (width >= 64) begin
      return 1'b1;
    end
    return value < (64'd1 << width);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One conditioned button: two-flop synchroniser, stable-time filter FSM,
// registered level and single-cycle press/release strobes with optional repeat.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REP_W         = 24,
  parameter int unsigned REPEAT_DELAY  = 5000000,
  parameter int unsigned REPEAT_RATE   = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic             sync1_q, sync2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rcnt_q, rcnt_d;
  logic             first_q, first_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      first_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    first_d = first_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = P_VERIFY;
          cnt_d   = '0;
        end
      end

      P_VERIFY: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          rcnt_d  = '0;
          first_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HELD: begin
        if (!sync2_q) begin
          state_d = R_VERIFY;
          cnt_d   = '0;
        end else if (REPEAT_EN != 0) begin
          // First repeat waits the long delay; later ones use the rate.
          if (rcnt_q == (first_q ? RATE_LAST : DELAY_LAST)) begin
            press_d = 1'b1;
            rcnt_d  = '0;
            first_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + REP_W'(1);
          end
        end
      end

      R_VERIFY: begin
        // A bounce back to HELD keeps rcnt/first so repeat timing resumes.
        if (sync2_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/button_debounce_array.sv
// N independent pushbutton conditioners between raw board switches and game logic.
module button_debounce_array
  import debounce_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REP_W         = 24,
  parameter int unsigned REPEAT_DELAY  = 5000000,
  parameter int unsigned REPEAT_RATE   = 1000000
) (
  input  logic         CLK,
  input  logic         ACLR_L,
  input  logic [N-1:0] SW,
  output logic [N-1:0] LEVEL,
  output logic [N-1:0] PRESS,
  output logic [N-1:0] RELEASE
);

  if (!count_fits(longint'(STABLE_CYCLES), CNT_W)) begin : g_bad_stable
    $error("STABLE_CYCLES must be in 1 .. 2**CNT_W-1");
  end

  if (REPEAT_EN != 0 && (!count_fits(longint'(REPEAT_DELAY), REP_W) ||
                         !count_fits(longint'(REPEAT_RATE), REP_W))) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_RATE must be in 1 .. 2**REP_W-1");
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_chan
    debounce_chan #(
      .CNT_W        (CNT_W),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REP_W        (REP_W),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .clk_i    (CLK),
      .rst_ni   (ACLR_L),
      .sw_i     (SW[i]),
      .level_o  (LEVEL[i]),
      .press_o  (PRESS[i]),
      .release_o(RELEASE[i])
    );
  end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench: two 2-channel instances (plain and auto-repeat), expected strobes
// queued with their due cycle and checked every cycle along with the expected level.
module tb_button_debounce_array;

  typedef struct {
    int         due;
    int         dut;
    logic [1:0] press;
    logic [1:0] rel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw_a, sw_b;
  logic [1:0] level_a, press_a, rel_a;
  logic [1:0] level_b, press_b, rel_b;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [1:0] ep_a, er_a, ep_b, er_b;
  logic [1:0] lvl_a = '0;
  logic [1:0] lvl_b = '0;

  button_debounce_array #(
    .N(2), .CNT_W(8), .STABLE_CYCLES(4), .REPEAT_EN(0),
    .REP_W(8), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) u_dut_a (
    .CLK(clk), .ACLR_L(rst_n), .SW(sw_a),
    .LEVEL(level_a), .PRESS(press_a), .RELEASE(rel_a)
  );

  button_debounce_array #(
    .N(2), .CNT_W(8), .STABLE_CYCLES(4), .REPEAT_EN(1),
    .REP_W(8), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) u_dut_b (
    .CLK(clk), .ACLR_L(rst_n), .SW(sw_b),
    .LEVEL(level_b), .PRESS(press_b), .RELEASE(rel_b)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  function automatic void expect_ev(int due, int dut, logic [1:0] p, logic [1:0] r);
    sb.push_back('{due: due, dut: dut, press: p, rel: r});
  endfunction

  task automatic at(input int c);
    while (cyc != c) @(negedge clk);
  endtask

  // Monitor: collect strobes due this cycle, then compare every output.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      ep_a = '0; er_a = '0; ep_b = '0; er_b = '0;
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].due == cyc) begin
          if (sb[k].dut == 0) begin
            ep_a = ep_a | sb[k].press;
            er_a = er_a | sb[k].rel;
          end else begin
            ep_b = ep_b | sb[k].press;
            er_b = er_b | sb[k].rel;
          end
          sb.delete(k);
        end else if (sb[k].due < cyc) begin
          checks++;
          errors++;
          $error("FAIL sb_stale cyc=%0d observed=missed expected_due=%0d", cyc, sb[k].due);
          sb.delete(k);
        end
      end
      lvl_a = (lvl_a | ep_a) & ~er_a;
      lvl_b = (lvl_b | ep_b) & ~er_b;
      check("press_a", press_a, ep_a);
      check("release_a", rel_a, er_a);
      check("level_a", level_a, lvl_a);
      check("press_b", press_b, ep_b);
      check("release_b", rel_b, er_b);
      check("level_b", level_b, lvl_b);
    end
  end

  initial begin
    rst_n = 1'b0;
    sw_a  = 2'b00;
    sw_b  = 2'b00;

    at(3);   rst_n = 1'b1;

    // Plain press on ch0: first sampling edge 6, strobe registered at edge 12.
    at(5);   sw_a[0] = 1'b1; expect_ev(12, 0, 2'b01, 2'b00);

    // Two-sample low bounce while held: no release.
    at(20);  sw_a[0] = 1'b0;
    at(22);  sw_a[0] = 1'b1;

    at(30);  sw_a[0] = 1'b0; expect_ev(37, 0, 2'b00, 2'b01);

    // Three-cycle glitch: rejected.
    at(45);  sw_a[0] = 1'b1;
    at(48);  sw_a[0] = 1'b0;

    // Independence.
    at(60);  sw_a = 2'b11;   expect_ev(67, 0, 2'b11, 2'b00);
    at(80);  sw_a[1] = 1'b0; expect_ev(87, 0, 2'b00, 2'b10);
    at(95);  sw_a[0] = 1'b0; expect_ev(102, 0, 2'b00, 2'b01);

    // Reset during P_VERIFY with the button held: full latency after reset.
    at(110); sw_a[0] = 1'b1;
    at(113); rst_n = 1'b0;
    at(115); rst_n = 1'b1;   expect_ev(122, 0, 2'b01, 2'b00);
    at(130); sw_a[0] = 1'b0; expect_ev(137, 0, 2'b00, 2'b01);

    // Auto-repeat: ch0 held, ch1 joins so its initial press meets ch0's first repeat.
    at(140); sw_b[0] = 1'b1;
    expect_ev(147, 1, 2'b01, 2'b00);
    expect_ev(157, 1, 2'b01, 2'b00);
    expect_ev(160, 1, 2'b01, 2'b00);
    expect_ev(163, 1, 2'b01, 2'b00);
    expect_ev(166, 1, 2'b01, 2'b00);
    expect_ev(169, 1, 2'b01, 2'b00);
    at(150); sw_b[1] = 1'b1;
    expect_ev(157, 1, 2'b10, 2'b00);
    expect_ev(167, 1, 2'b10, 2'b00);
    expect_ev(170, 1, 2'b10, 2'b00);
    expect_ev(173, 1, 2'b10, 2'b00);
    expect_ev(176, 1, 2'b10, 2'b00);
    at(168); sw_b[0] = 1'b0; expect_ev(175, 1, 2'b00, 2'b01);
    at(175); sw_b[1] = 1'b0; expect_ev(182, 1, 2'b00, 2'b10);

    at(195);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d pending expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
